// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file for a multi-issue core. It has NRD
// combinational read ports and NWR synchronous write ports. A per-register busy
// scoreboard lets issue logic stall on RAW hazards. Register 0 always reads as
// zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to the address being read is forwarded to
//               rdata, so read-after-write has no bubble.
//   undefined : reads return stored state only.
//
// Ports
//   clk      in   1          clock, rising edge
//   rst      in   1          asynchronous reset, active low
//   rden     in   NRD        per-port read enable
//   raddr    in   NRD*AW     read addresses, port i at [i*AW +: AW]
//   rdata    out  NRD*XLEN   read data, packed like raddr
//   rbusy    out  NRD        scoreboard busy bit for each read address
//   wren     in   NWR        per-port write enable
//   waddr    in   NWR*AW     write addresses
//   wdata    in   NWR*XLEN   write data
//   iss_en   in   1          an instruction issues and marks iss_addr busy
//   iss_addr in   AW         issued destination register
//   flush    in   1          clears every busy bit
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rden,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       wren,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Scoreboard next state. Assignments run from lowest to highest priority,
    // so the last one that applies wins: writeback clear, then issue set, then
    // flush. Register 0 is never busy.
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wren[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                    busy_nxt[r] = 1'b0;
                end
            end
            if (iss_en && (iss_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Storage and scoreboard. Register 0 is cleared at reset and never written.
    // Within one cycle the inner port loop lets the higher-index port's
    // non-blocking assignment land last, so it wins a same-address conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wren[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                        regs[r] <= wdata[j*XLEN +: XLEN];
                    end
                end
            end
            busy <= busy_nxt;
        end
    end

    // Combinational read ports. Disabled ports and address 0 return zeros.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rden[i] && (raddr[i*AW +: AW] != '0)) begin
                rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
                rbusy[i]              = busy[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Forward an in-flight write. Gated by rst so that outputs
                // stay zero while reset is held. A forwarded value is no longer
                // busy unless a new producer issues to it this same cycle.
                for (int j = 0; j < NWR; j++) begin
                    if (rst && wren[j] &&
                        (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                        rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                        rbusy[i] = iss_en && !flush &&
                                   (iss_addr == raddr[i*AW +: AW]);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    // ------------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NRD-1:0]      rden;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wren;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rden     (rden),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .wren     (wren),
        .waddr    (waddr),
        .wdata    (wdata),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // ------------------------------------------------------------------ reference model
    // Architectural state as plain arrays, updated from the rules of the
    // register file: writes in port order, then the busy priority list.
    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_busy [NREG];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            bit nb [NREG];
            for (int r = 0; r < NREG; r++) nb[r] = m_busy[r];
            for (int j = 0; j < NWR; j++) begin
                int a;
                a = int'(waddr[j*AW +: AW]);
                if (wren[j]) begin
                    if (a != 0) m_reg[a] = wdata[j*XLEN +: XLEN];
                    nb[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
            if (flush) for (int r = 0; r < NREG; r++) nb[r] = 1'b0;
            nb[0] = 1'b0;
            for (int r = 0; r < NREG; r++) m_busy[r] = nb[r];
        end
    end

    function automatic logic [XLEN-1:0] exp_data(int i);
        int a;
        logic [XLEN-1:0] v;
        a = int'(raddr[i*AW +: AW]);
        if (!rst || !rden[i] || a == 0) return '0;
        v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wren[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(int i);
        int a;
        logic b;
        a = int'(raddr[i*AW +: AW]);
        if (!rst || !rden[i] || a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wren[j] && int'(waddr[j*AW +: AW]) == a)
                b = iss_en && !flush && (int'(iss_addr) == a);
`endif
        return b;
    endfunction

    // ------------------------------------------------------------------ scoreboard
    logic [XLEN:0] exp_q[$];

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negative edge: queue the model's view of each port, then pop and
    // compare against the DUT.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NRD; i++) exp_q.push_back({exp_busy(i), exp_data(i)});
            for (int i = 0; i < NRD; i++) begin
                logic [XLEN:0] e;
                e = exp_q.pop_front();
                check($sformatf("cmp_rdata%0d", i), rdata[i*XLEN +: XLEN], e[XLEN-1:0]);
                check($sformatf("cmp_rbusy%0d", i), XLEN'(rbusy[i]), XLEN'(e[XLEN]));
            end
        end
    end

    // ------------------------------------------------------------------ driver tasks
    task automatic set_idle();
        rden = '0; raddr = '0; wren = '0; waddr = '0; wdata = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_read(int p, int a);
        rden[p] = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_write(int p, int a, logic [XLEN-1:0] d);
        wren[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_random();
        rden = NRD'($urandom);
        wren = NWR'($urandom);
        for (int i = 0; i < NRD; i++)
            raddr[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
        for (int j = 0; j < NWR; j++) begin
            waddr[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
            wdata[j*XLEN +: XLEN] = $urandom;
        end
        iss_en   = ($urandom_range(0, 2) == 0);
        iss_addr = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
        flush    = ($urandom_range(0, 15) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ------------------------------------------------------------------ watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------ stimulus
    initial begin
        set_idle();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset held with garbage on every input: outputs must stay zero.
        repeat (3) begin
            set_random();
            tick();
        end
        settle();
        check("rst_rdata0", rdata[0 +: XLEN], 32'h0);
        check("rst_rdata1", rdata[XLEN +: XLEN], 32'h0);
        check("rst_rbusy", XLEN'(rbusy), 32'h0);

        @(negedge clk);
        set_idle();
        #1;
        rst = 1'b1;
        set_read(0, 5);
        settle();
        check("read_r5_after_reset", rdata[0 +: XLEN], 32'h0);
        tick();

        // Dual write conflict: port 1 wins.
        set_idle();
        set_write(1, 7, 32'hBBBB0000);
        set_write(0, 7, 32'hAAAA0000);
        tick();
        set_idle();
        set_read(0, 7);
        settle();
        check("dual_write_r7", rdata[0 +: XLEN], 32'hBBBB0000);
        set_idle();
        set_write(0, 0, 32'h1234);
        tick();
        set_idle();
        set_read(0, 0);
        settle();
        check("write_r0_discarded", rdata[0 +: XLEN], 32'h0);

        // Scoreboard lifecycle on r9.
        set_idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        set_idle();
        set_read(0, 9);
        settle();
        check("sb_issue_busy", XLEN'(rbusy[0]), 32'h1);
        set_idle();
        set_write(0, 9, 32'h55);
        tick();
        set_idle();
        set_read(0, 9);
        settle();
        check("sb_wb_busy", XLEN'(rbusy[0]), 32'h0);
        check("sb_wb_data", rdata[0 +: XLEN], 32'h55);
        set_idle();
        set_write(0, 9, 32'h66);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        set_idle();
        set_read(0, 9);
        settle();
        check("sb_issue_over_wb", XLEN'(rbusy[0]), 32'h1);

        // Flush beats a same-cycle issue.
        set_idle();
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd4;
        tick();
        set_idle();
        set_read(0, 3);
        set_read(1, 4);
        settle();
        check("flush_pre_busy", XLEN'(rbusy), 32'h3);
        set_idle();
        flush = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        set_idle();
        set_read(0, 3);
        set_read(1, 4);
        settle();
        check("flush_r3_r4", XLEN'(rbusy), 32'h0);
        set_idle();
        set_read(0, 6);
        settle();
        check("flush_r6", XLEN'(rbusy[0]), 32'h0);

        // Bypass: write r12 while port 1 reads it.
        set_idle();
        set_write(0, 12, 32'h11);
        tick();
        set_idle();
        set_write(0, 12, 32'hDEADBEEF);
        set_read(1, 12);
        settle();
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rdata[XLEN +: XLEN], 32'hDEADBEEF);
`else
        check("bypass_same_cycle", rdata[XLEN +: XLEN], 32'h11);
`endif
        tick();
        set_idle();
        set_read(1, 12);
        settle();
        check("bypass_next_cycle", rdata[XLEN +: XLEN], 32'hDEADBEEF);

        // Asynchronous reset mid-cycle.
        set_idle();
        set_write(0, 2, 32'h77);
        iss_en = 1'b1; iss_addr = 5'd2;
        tick();
        set_idle();
        set_read(0, 2);
        settle();
        check("pre_areset_data", rdata[0 +: XLEN], 32'h77);
        check("pre_areset_busy", XLEN'(rbusy[0]), 32'h1);
        set_write(1, 2, 32'h99);
        rst = 1'b0;
        #1;
        check("areset_data", rdata[0 +: XLEN], 32'h0);
        check("areset_busy", XLEN'(rbusy[0]), 32'h0);
        @(negedge clk);
        set_idle();
        #1;
        rst = 1'b1;
        set_read(0, 2);
        settle();
        check("areset_write_lost", rdata[0 +: XLEN], 32'h0);

        // Randomized traffic against the model, with rare reset pulses.
        for (int n = 0; n < 3000; n++) begin
            tick();
            set_random();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1;
                check("rand_areset_data", rdata[0 +: XLEN], 32'h0);
                @(negedge clk);
                #1;
                rst = 1'b1;
            end
        end
        tick();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
